// File: rtl/tlb_walk_arbiter.sv
// tlb_walk_arbiter: shares one page-table walker between the ITLB and the DTLB.
// Grants a requester, issues a one-cycle walk request, waits for the walker,
// then writes back the entry or reports a fault. A TLB flush during a walk
// aborts it and drains the walker's acknowledge.
// Optional build macro: TLB_WALK_TIMEOUT_EN adds a walk watchdog (TIMEOUT_CYCLES)
// and drives the sticky WalkTimeout flag; without it WalkTimeout is tied 0.
//
// Handshake: ITLBMissF/DTLBMissM are levels held by the requester until serviced.
// WalkReq is a one-cycle start pulse to the walker. WalkSelData is registered at
// grant time and stays stable from WalkReq until the walk completes. WalkDone is
// a one-cycle pulse from the walker (WalkFault only meaningful with it); the
// write/fault/abort pulses are produced combinationally in the cycle they apply.
module tlb_walk_arbiter #(
    parameter int STARVE_LIMIT = 3
`ifdef TLB_WALK_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ITLBMissF,
    input  logic DTLBMissM,
    input  logic TLBFlush,
    input  logic WalkDone,
    input  logic WalkFault,
    output logic WalkReq,
    output logic WalkSelData,
    output logic ITLBWrite,
    output logic DTLBWrite,
    output logic WalkFaultI,
    output logic WalkFaultD,
    output logic WalkAbort,
    output logic Busy,
    output logic WalkTimeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

    // state is kept as a named typed signal so external checkers can bind to it
    state_t        state;
    state_t        state_next;
    logic [SW-1:0] starve_cnt;
    logic          starve_at_limit;
    logic          grant;
    logic          grant_data;
    logic          flush_pend;

`ifdef TLB_WALK_TIMEOUT_EN
    localparam int WDW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    logic [WDW-1:0] wd_cnt;
    logic           timeout_reached;
    logic           timeout_hit;
    logic           timeout_flag;

    assign timeout_reached = (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));
`endif

    assign starve_at_limit = (starve_cnt == SW'(STARVE_LIMIT));
    assign Busy            = (state != IDLE);

    // next-state, grant decision and completion pulses
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_data = 1'b0;
        ITLBWrite  = 1'b0;
        DTLBWrite  = 1'b0;
        WalkFaultI = 1'b0;
        WalkFaultD = 1'b0;
        WalkAbort  = 1'b0;
`ifdef TLB_WALK_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            IDLE: begin
                // a flush in IDLE suppresses granting for that cycle
                if ((ITLBMissF || DTLBMissM) && !TLBFlush) begin
                    grant      = 1'b1;
                    grant_data = DTLBMissM && !(ITLBMissF && starve_at_limit);
                    state_next = REQ;
                end
            end
            REQ: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (TLBFlush || flush_pend) begin
                    // flush beats a same-cycle WalkDone: walker already idle, no abort
                    if (!WalkDone) begin
                        WalkAbort  = 1'b1;
                        state_next = DRAIN;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (WalkDone) begin
                    state_next = IDLE;
                    if (WalkFault) begin
                        WalkFaultD = WalkSelData;
                        WalkFaultI = !WalkSelData;
                    end else begin
                        DTLBWrite = WalkSelData;
                        ITLBWrite = !WalkSelData;
                    end
                end
`ifdef TLB_WALK_TIMEOUT_EN
                else if (timeout_reached) begin
                    WalkAbort   = 1'b1;
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
`endif
            end
            DRAIN: begin
                // the walker always acknowledges an abort with WalkDone
                if (WalkDone) begin
                    state_next = IDLE;
                end
`ifdef TLB_WALK_TIMEOUT_EN
                else if (timeout_reached) begin
                    WalkAbort   = 1'b1;
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // walk request pulse, requester select and flush-in-REQ memory
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            WalkReq     <= 1'b0;
            WalkSelData <= 1'b0;
            flush_pend  <= 1'b0;
        end else begin
            WalkReq    <= (state == REQ);
            flush_pend <= (state == REQ) && TLBFlush;
            if (grant) begin
                WalkSelData <= grant_data;
            end
        end
    end

    // starve counter: counts DTLB grants made while an ITLB miss waits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (grant_data && ITLBMissF) begin
                if (!starve_at_limit) begin
                    starve_cnt <= starve_cnt + SW'(1);
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

`ifdef TLB_WALK_TIMEOUT_EN
    // watchdog counter: restarts on entry to WAIT/DRAIN, counts cycles spent there
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
        end else if ((state_next != state) && ((state_next == WAIT) || (state_next == DRAIN))) begin
            wd_cnt <= '0;
        end else if ((state == WAIT) || (state == DRAIN)) begin
            wd_cnt <= wd_cnt + WDW'(1);
        end
    end

    // sticky timeout flag, cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_flag <= 1'b0;
        end else if (timeout_hit) begin
            timeout_flag <= 1'b1;
        end
    end

    assign WalkTimeout = timeout_flag;
`else
    assign WalkTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_tlb_walk_arbiter.sv
// Bench for tlb_walk_arbiter: directed stimulus pushes timed expected output
// events into a queue; a monitor on the falling edge pops and compares.
module tb_tlb_walk_arbiter;

    localparam int EW = 39;  // {cycle[31:0], event[6:0]}

    logic clk = 1'b0;
    logic reset_n;
    logic ITLBMissF, DTLBMissM, TLBFlush, WalkDone, WalkFault;
    logic WalkReq, WalkSelData, ITLBWrite, DTLBWrite;
    logic WalkFaultI, WalkFaultD, WalkAbort, Busy, WalkTimeout;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // event bits: {WalkReq, WalkSelData, ITLBWrite, DTLBWrite, WalkFaultI, WalkFaultD, WalkAbort}
    logic [EW-1:0] exp_q[$];

    tlb_walk_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ITLBMissF  (ITLBMissF),
        .DTLBMissM  (DTLBMissM),
        .TLBFlush   (TLBFlush),
        .WalkDone   (WalkDone),
        .WalkFault  (WalkFault),
        .WalkReq    (WalkReq),
        .WalkSelData(WalkSelData),
        .ITLBWrite  (ITLBWrite),
        .DTLBWrite  (DTLBWrite),
        .WalkFaultI (WalkFaultI),
        .WalkFaultD (WalkFaultD),
        .WalkAbort  (WalkAbort),
        .Busy       (Busy),
        .WalkTimeout(WalkTimeout)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // run-time bound
    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, cycle=%0d", cyc);
        $fatal(1, "bench watchdog expired");
    end

    // monitor: compare every output event against the scoreboard head
    always @(negedge clk) begin
        logic [6:0]    ev;
        logic [EW-1:0] head;
        logic [31:0]   now;
        now = cyc;
        ev  = {WalkReq, WalkSelData, ITLBWrite, DTLBWrite, WalkFaultI, WalkFaultD, WalkAbort};
        while (exp_q.size() > 0) begin
            head = exp_q[0];
            if (head[EW-1:7] >= now) break;
            checks++;
            failures++;
            $display("FAIL missing_event: expected ev=%b at cycle %0d, no event observed", head[6:0], head[EW-1:7]);
            void'(exp_q.pop_front());
        end
        if ((ev & 7'b1011111) != 7'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: got ev=%b at cycle %0d, expected nothing", ev, now);
            end else begin
                head = exp_q.pop_front();
                if (head != {now, ev}) begin
                    failures++;
                    $display("FAIL event: got ev=%b at cycle %0d, expected ev=%b at cycle %0d",
                             ev, now, head[6:0], head[EW-1:7]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic expect_ev(input int at, input logic [6:0] ev);
        logic [31:0] a;
        a = at;
        exp_q.push_back({a, ev});
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // directed stimulus
    initial begin
        int b;
        reset_n   = 1'b0;
        ITLBMissF = 1'b0;
        DTLBMissM = 1'b0;
        TLBFlush  = 1'b0;
        WalkDone  = 1'b0;
        WalkFault = 1'b0;
        #1;
        check_bit("rst_busy", Busy, 1'b0);
        check_bit("rst_req", WalkReq, 1'b0);
        check_bit("rst_sel", WalkSelData, 1'b0);
        check_bit("rst_timeout", WalkTimeout, 1'b0);
        check_bit("rst_pulses", |{ITLBWrite, DTLBWrite, WalkFaultI, WalkFaultD, WalkAbort}, 1'b0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // single DTLB walk, done 4 cycles after WalkReq
        b = cyc;
        DTLBMissM = 1'b1;
        expect_ev(b + 2, 7'b1100000);
        expect_ev(b + 6, 7'b0101000);
        wait_until(b + 1);
        check_bit("t1_busy_req", Busy, 1'b1);
        check_bit("t1_sel_early", WalkSelData, 1'b1);
        wait_until(b + 6);
        WalkDone = 1'b1;
        DTLBMissM = 1'b0;
        tick();
        WalkDone = 1'b0;
        check_bit("t1_busy_after", Busy, 1'b0);

        // both misses held: grant order D,D,D,I,D,D,D,I
        tick();
        b = cyc;
        ITLBMissF = 1'b1;
        DTLBMissM = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic d;
            d = ((k % 4) != 3);
            expect_ev(b + 2 + 7 * k, {1'b1, d, 5'b00000});
            expect_ev(b + 6 + 7 * k, {1'b0, d, !d, d, 3'b000});
        end
        for (int k = 0; k < 8; k++) begin
            wait_until(b + 6 + 7 * k);
            WalkDone = 1'b1;
            if (k == 7) begin
                ITLBMissF = 1'b0;
                DTLBMissM = 1'b0;
            end
            tick();
            WalkDone = 1'b0;
        end
        check_bit("t2_busy_after", Busy, 1'b0);

        // D grant with I pending (counter 1), then ITLB walk faults, counter clears
        tick();
        b = cyc;
        ITLBMissF = 1'b1;
        DTLBMissM = 1'b1;
        expect_ev(b + 2, 7'b1100000);
        expect_ev(b + 4, 7'b0101000);
        expect_ev(b + 7, 7'b1000000);
        expect_ev(b + 9, 7'b0000100);
        wait_until(b + 4);
        WalkDone = 1'b1;
        DTLBMissM = 1'b0;
        tick();
        WalkDone = 1'b0;
        check_bit("t3_starve_one", dut.starve_cnt == 2'd1, 1'b1);
        wait_until(b + 9);
        WalkDone = 1'b1;
        WalkFault = 1'b1;
        ITLBMissF = 1'b0;
        tick();
        WalkDone = 1'b0;
        WalkFault = 1'b0;
        check_bit("t3_busy_after", Busy, 1'b0);
        check_bit("t3_starve_zero", dut.starve_cnt == 2'd0, 1'b1);

        // DTLB walk, flush in WAIT, walker acknowledges 2 cycles later
        tick();
        b = cyc;
        DTLBMissM = 1'b1;
        expect_ev(b + 2, 7'b1100000);
        expect_ev(b + 5, 7'b0100001);
        wait_until(b + 5);
        TLBFlush = 1'b1;
        DTLBMissM = 1'b0;
        tick();
        TLBFlush = 1'b0;
        check_bit("t4_busy_drain", Busy, 1'b1);
        tick();
        WalkDone = 1'b1;
        check_bit("t4_busy_drain2", Busy, 1'b1);
        tick();
        WalkDone = 1'b0;
        check_bit("t4_busy_after", Busy, 1'b0);

        // flush and WalkDone together: no write, no abort, IDLE next cycle
        tick();
        b = cyc;
        DTLBMissM = 1'b1;
        expect_ev(b + 2, 7'b1100000);
        wait_until(b + 4);
        TLBFlush = 1'b1;
        WalkDone = 1'b1;
        DTLBMissM = 1'b0;
        tick();
        TLBFlush = 1'b0;
        WalkDone = 1'b0;
        check_bit("t5_busy_after", Busy, 1'b0);

        // flush in REQ: WalkReq still issued, abort in the following cycle
        tick();
        b = cyc;
        DTLBMissM = 1'b1;
        expect_ev(b + 2, 7'b1100001);
        wait_until(b + 1);
        TLBFlush = 1'b1;
        DTLBMissM = 1'b0;
        tick();
        TLBFlush = 1'b0;
        tick();
        check_bit("t6_busy_drain", Busy, 1'b1);
        WalkDone = 1'b1;
        tick();
        WalkDone = 1'b0;
        check_bit("t6_busy_after", Busy, 1'b0);

        // flush in IDLE blocks the grant for one cycle
        tick();
        b = cyc;
        DTLBMissM = 1'b1;
        TLBFlush = 1'b1;
        expect_ev(b + 3, 7'b1100000);
        expect_ev(b + 5, 7'b0101000);
        tick();
        TLBFlush = 1'b0;
        check_bit("t7_no_grant", Busy, 1'b0);
        wait_until(b + 5);
        WalkDone = 1'b1;
        DTLBMissM = 1'b0;
        tick();
        WalkDone = 1'b0;
        check_bit("t7_busy_after", Busy, 1'b0);

        // WalkDone in IDLE and in REQ is ignored
        tick();
        WalkDone = 1'b1;
        tick();
        WalkDone = 1'b0;
        check_bit("t8_idle_done", Busy, 1'b0);
        b = cyc;
        DTLBMissM = 1'b1;
        expect_ev(b + 2, 7'b1100000);
        expect_ev(b + 4, 7'b0101000);
        wait_until(b + 1);
        WalkDone = 1'b1;
        tick();
        WalkDone = 1'b0;
        check_bit("t8_req_done_ignored", Busy, 1'b1);
        wait_until(b + 4);
        WalkDone = 1'b1;
        DTLBMissM = 1'b0;
        tick();
        WalkDone = 1'b0;

        // miss drops mid-walk: data fault still reported
        tick();
        b = cyc;
        DTLBMissM = 1'b1;
        expect_ev(b + 2, 7'b1100000);
        expect_ev(b + 4, 7'b0100010);
        wait_until(b + 2);
        DTLBMissM = 1'b0;
        wait_until(b + 4);
        WalkDone = 1'b1;
        WalkFault = 1'b1;
        tick();
        WalkDone = 1'b0;
        WalkFault = 1'b0;
        check_bit("t9_busy_after", Busy, 1'b0);

        // asynchronous reset mid-walk
        tick();
        b = cyc;
        DTLBMissM = 1'b1;
        expect_ev(b + 2, 7'b1100000);
        wait_until(b + 3);
        #2;
        reset_n = 1'b0;
        #1;
        check_bit("t10_async_busy", Busy, 1'b0);
        check_bit("t10_async_sel", WalkSelData, 1'b0);
        DTLBMissM = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check_bit("t10_busy_after", Busy, 1'b0);

        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d events left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
